// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit.
// Multiply is a shift-add over operand magnitudes. Divide is restoring division.
// Both process one bit per clock.
// Divide-by-zero and signed overflow finish in one cycle without entering CALC.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int unsigned CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_t;

  state_t              r_state, w_state_d;
  logic [CW-1:0]       r_cnt, w_cnt_d;
  logic [2:0]          r_f3, w_f3_d;
  logic                r_neg_q, w_neg_q_d;   // negate product / quotient
  logic                r_neg_r, w_neg_r_d;   // negate remainder (dividend sign)
  logic [2*XLEN-1:0]   r_acc, w_acc_d;       // mul: {hi, multiplier}; div: {rem, quot}
  logic [XLEN-1:0]     r_b, w_b_d;           // multiplicand or divisor magnitude
  logic [XLEN-1:0]     r_result, w_result_d;

  // Operand decode at acceptance
  logic            w_div, w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic [XLEN-1:0] w_a_mag, w_b_mag;
  logic            w_div_zero, w_ovf;
  logic [XLEN-1:0] w_fast_result;

  // Decode signedness, magnitudes and fast-path cases from the live inputs
  always_comb begin
    w_div      = i_funct3[2];
    w_a_signed = w_div ? ~i_funct3[0] : (i_funct3[1:0] == 2'b01 || i_funct3[1:0] == 2'b10);
    w_b_signed = w_div ? ~i_funct3[0] : (i_funct3[1:0] == 2'b01);
    w_a_neg    = w_a_signed & i_rs1[XLEN-1];
    w_b_neg    = w_b_signed & i_rs2[XLEN-1];
    // Unsigned XLEN-bit magnitude keeps |-2^(XLEN-1)| exact
    w_a_mag    = w_a_neg ? -i_rs1 : i_rs1;
    w_b_mag    = w_b_neg ? -i_rs2 : i_rs2;
    w_div_zero = w_div && (i_rs2 == '0);
    w_ovf      = w_div && !i_funct3[0] && (i_rs1 == MinNeg) && (i_rs2 == '1);
    w_fast_result = '0;
    if (w_div_zero) begin
      w_fast_result = i_funct3[1] ? i_rs1 : '1;
    end else if (w_ovf) begin
      w_fast_result = i_funct3[1] ? '0 : MinNeg;
    end
  end

  // One iteration of the datapath and the result formed from its output
  logic [XLEN:0]     w_mul_sum, w_trial;
  logic [2*XLEN-1:0] w_mul_next, w_div_next, w_step, w_prod_s;
  logic [XLEN-1:0]   w_quot_s, w_rem_s, w_final;

  // Shift-add and restoring-divide step, then sign fix-up and funct3 select
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
    w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};
    // Partial remainder shifted left with the next dividend bit, minus divisor
    w_trial    = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_b};
    w_div_next = w_trial[XLEN] ? {r_acc[2*XLEN-2:0], 1'b0}
                               : {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
    w_step     = r_f3[2] ? w_div_next : w_mul_next;
    w_prod_s   = r_neg_q ? -w_step : w_step;
    w_quot_s   = r_neg_q ? -w_step[XLEN-1:0] : w_step[XLEN-1:0];
    w_rem_s    = r_neg_r ? -w_step[2*XLEN-1:XLEN] : w_step[2*XLEN-1:XLEN];
    unique case (r_f3)
      3'b000:                 w_final = w_prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_final = w_prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_final = w_quot_s;
      default:                w_final = w_rem_s;
    endcase
  end

  // Next-state logic for the IDLE/CALC/DONE sequencer and datapath registers
  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_f3_d     = r_f3;
    w_neg_q_d  = r_neg_q;
    w_neg_r_d  = r_neg_r;
    w_acc_d    = r_acc;
    w_b_d      = r_b;
    w_result_d = r_result;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_f3_d    = i_funct3;
          w_neg_q_d = w_a_neg ^ w_b_neg;
          w_neg_r_d = w_a_neg;
          w_acc_d   = {{XLEN{1'b0}}, w_a_mag};
          w_b_d     = w_b_mag;
          if (w_div_zero || w_ovf) begin
            w_result_d = w_fast_result;
            w_state_d  = StDone;
          end else begin
            w_cnt_d   = CW'(XLEN);
            w_state_d = StCalc;
          end
        end
      end
      StCalc: begin
        w_acc_d = w_step;
        w_cnt_d = r_cnt - 1'b1;
        if (r_cnt == CW'(1)) begin
          w_result_d = w_final;
          w_state_d  = StDone;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_f3     <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_acc    <= '0;
      r_b      <= '0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_f3     <= w_f3_d;
      r_neg_q  <= w_neg_q_d;
      r_neg_r  <= w_neg_r_d;
      r_acc    <= w_acc_d;
      r_b      <= w_b_d;
      r_result <= w_result_d;
    end
  end

  assign o_busy   = (r_state != StIdle);
  assign o_done   = (r_state == StDone);
  assign o_result = r_result;

endmodule
